// File: rtl/imc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imc_pkg
//  Description : Shared op encodings, sequencer states and ADC saturation
//                helper for the compute-in-memory array sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package imc_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_MAC   = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_PRECH = 3'd2,
        ST_EVAL  = 3'd3,
        ST_SENSE = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    // Scale a column count down and clamp it to the largest code the ADC can emit.
    function automatic int unsigned sat_code(input int unsigned cnt,
                                             input int unsigned shift,
                                             input int unsigned bits);
        int unsigned shifted;
        int unsigned max_code;
        shifted  = cnt >> shift;
        max_code = (32'd1 << bits) - 32'd1;
        return (shifted > max_code) ? max_code : shifted;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imc_col_adc.sv
`default_nettype none
// ============================================================================
//  Module      : imc_col_adc
//  Description : One bitline column: counts activated rows holding a 1 and
//                converts the count to a saturating ADC code.
//  Revision    : 1.0 - initial release
// ============================================================================
module imc_col_adc
    import imc_pkg::*;
#(
    parameter int ROWS      = 16,
    parameter int ADC_BITS  = 4,
    parameter int ADC_SHIFT = 0
) (
    input  logic [ROWS-1:0]     col_bits,
    input  logic [ROWS-1:0]     act,
    output logic [ADC_BITS-1:0] code
);

    localparam int CNT_W = $clog2(ROWS + 1);

    logic [CNT_W-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int r = 0; r < ROWS; r++) begin
            cnt = cnt + CNT_W'(col_bits[r] & act[r]);
        end
        code = ADC_BITS'(sat_code(32'(cnt), ADC_SHIFT, ADC_BITS));
    end

endmodule
`default_nettype wire

// File: rtl/imc_array_seq.sv
`default_nettype none
// ============================================================================
//  Module      : imc_array_seq
//  Description : ROWS x COLS 1-bit weight array with write / row read /
//                in-memory MAC sequencing through precharge, evaluate and
//                sense phases, and a valid/ready response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module imc_array_seq
    import imc_pkg::*;
#(
    parameter int ROWS      = 16,
    parameter int COLS      = 16,
    parameter int ADC_BITS  = 4,
    parameter int ADC_SHIFT = 0,
    parameter int PRE_CYC   = 2,
    parameter int EVAL_CYC  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [$clog2(ROWS)-1:0]    cmd_row,
    input  logic [COLS-1:0]            cmd_wdata,
    input  logic [ROWS-1:0]            cmd_act,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [COLS-1:0]            rsp_rdata,
    output logic [COLS*ADC_BITS-1:0]   rsp_adc,
    output logic                       pre_o,
    output logic                       eval_o,
    output logic                       saen_o,
    output logic                       we_o,
    output logic                       busy
);

    localparam int RW     = $clog2(ROWS);
    localparam int PH_MAX = (PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0] PRE_LAST  = PH_W'(PRE_CYC - 1);
    localparam logic [PH_W-1:0] EVAL_LAST = PH_W'(EVAL_CYC - 1);
    localparam logic [RW:0]     ROWS_L    = (RW + 1)'(ROWS);

    state_t                     state_q, state_d;
    logic [PH_W-1:0]            ph_q, ph_d;
    logic [1:0]                 op_q, op_d;
    logic [RW-1:0]              row_q, row_d;
    logic [COLS-1:0]            wdata_q, wdata_d;
    logic [ROWS-1:0]            act_q, act_d;

    logic                       rsp_valid_q, rsp_valid_d;
    logic [COLS-1:0]            rdata_q, rdata_d;
    logic [COLS*ADC_BITS-1:0]   adc_q, adc_d;
    logic                       pre_q, pre_d;
    logic                       eval_q, eval_d;
    logic                       saen_q, saen_d;
    logic                       we_q, we_d;

    // Weight array is deliberately left out of reset.
    logic [COLS-1:0]            mem_q [ROWS];

    logic                       row_ok;
    logic [ROWS-1:0]            col_bits [COLS];
    logic [COLS*ADC_BITS-1:0]   codes;

    assign row_ok = ({1'b0, row_q} < ROWS_L);

    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                col_bits[c][r] = mem_q[r][c];
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        imc_col_adc #(
            .ROWS      (ROWS),
            .ADC_BITS  (ADC_BITS),
            .ADC_SHIFT (ADC_SHIFT)
        ) u_col_adc (
            .col_bits (col_bits[c]),
            .act      (act_q),
            .code     (codes[c*ADC_BITS +: ADC_BITS])
        );
    end

    // Next-state and command capture.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        op_d    = op_q;
        row_d   = row_q;
        wdata_d = wdata_q;
        act_d   = act_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    row_d   = cmd_row;
                    wdata_d = cmd_wdata;
                    act_d   = cmd_act;
                    ph_d    = '0;
                    case (cmd_op)
                        OP_WRITE: state_d = ST_WRITE;
                        OP_READ:  state_d = ST_PRECH;
                        OP_MAC:   state_d = ST_PRECH;
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_PRECH: begin
                if (ph_q == PRE_LAST) begin
                    ph_d    = '0;
                    state_d = ST_EVAL;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_EVAL: begin
                if (ph_q == EVAL_LAST) begin
                    ph_d    = '0;
                    state_d = ST_SENSE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_SENSE: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes follow the upcoming state so they are registered yet phase-aligned.
    always_comb begin
        pre_d       = (state_d == ST_PRECH);
        eval_d      = (state_d == ST_EVAL);
        saen_d      = (state_d == ST_SENSE);
        we_d        = (state_d == ST_WRITE);
        rsp_valid_d = (state_d == ST_RESP);
        rdata_d     = rdata_q;
        adc_d       = adc_q;
        if (state_q == ST_SENSE) begin
            if (op_q == OP_MAC) begin
                rdata_d = '0;
                adc_d   = codes;
            end else begin
                rdata_d = row_ok ? mem_q[row_q] : '0;
                adc_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ph_q        <= '0;
            op_q        <= OP_NOP;
            row_q       <= '0;
            wdata_q     <= '0;
            act_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            adc_q       <= '0;
            pre_q       <= 1'b0;
            eval_q      <= 1'b0;
            saen_q      <= 1'b0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            op_q        <= op_d;
            row_q       <= row_d;
            wdata_q     <= wdata_d;
            act_q       <= act_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            adc_q       <= adc_d;
            pre_q       <= pre_d;
            eval_q      <= eval_d;
            saen_q      <= saen_d;
            we_q        <= we_d;
        end
    end

    // A reset forces state_q out of WRITE immediately, so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (state_q == ST_WRITE && row_ok) begin
            mem_q[row_q] <= wdata_q;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_adc   = adc_q;
    assign pre_o     = pre_q;
    assign eval_o    = eval_q;
    assign saen_o    = saen_q;
    assign we_o      = we_q;

endmodule
`default_nettype wire

// File: tb/tb_imc_array_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imc_array_seq
//  Description : Directed and random checks of two sequencer builds (default,
//                and ROWS=12 / ADC_SHIFT=1) against an array-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imc_array_seq;

    localparam logic [14:0] STROBE_SEQ = 15'b100_100_010_010_001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]        pre_o, eval_o, saen_o, we_o, busy;
    logic [1:0][1:0]   cmd_op;
    logic [1:0][3:0]   cmd_row;
    logic [1:0][15:0]  cmd_wdata, cmd_act, rsp_rdata;
    logic [1:0][63:0]  rsp_adc;

    logic [15:0] mem_m [2][16];
    int          nrows [2];
    int          shft  [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    imc_array_seq #(
        .ROWS(16), .COLS(16), .ADC_BITS(4), .ADC_SHIFT(0), .PRE_CYC(2), .EVAL_CYC(2)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
        .cmd_row(cmd_row[0]), .cmd_wdata(cmd_wdata[0]), .cmd_act(cmd_act[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_adc(rsp_adc[0]), .pre_o(pre_o[0]), .eval_o(eval_o[0]), .saen_o(saen_o[0]),
        .we_o(we_o[0]), .busy(busy[0])
    );

    imc_array_seq #(
        .ROWS(12), .COLS(16), .ADC_BITS(4), .ADC_SHIFT(1), .PRE_CYC(2), .EVAL_CYC(2)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
        .cmd_row(cmd_row[1]), .cmd_wdata(cmd_wdata[1]), .cmd_act(cmd_act[1][11:0]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_adc(rsp_adc[1]), .pre_o(pre_o[1]), .eval_o(eval_o[1]), .saen_o(saen_o[1]),
        .we_o(we_o[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s: observed timeout expected response", tag);
    endtask

    function automatic logic [63:0] mac_model(input int d, input logic [15:0] act);
        logic [63:0] res;
        int cnt;
        int code;
        res = '0;
        for (int c = 0; c < 16; c++) begin
            cnt = 0;
            for (int r = 0; r < nrows[d]; r++) begin
                if (act[r] && mem_m[d][r][c]) cnt++;
            end
            code = cnt >> shft[d];
            if (code > 15) code = 15;
            res[c*4 +: 4] = code[3:0];
        end
        return res;
    endfunction

    task automatic issue(input int d, input logic [1:0] op, input logic [3:0] row,
                         input logic [15:0] wd, input logic [15:0] act);
        int k;
        @(negedge clk);
        k = 0;
        while (cmd_ready[d] !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) timeout("cmd_ready");
        cmd_op[d]    = op;
        cmd_row[d]   = row;
        cmd_wdata[d] = wd;
        cmd_act[d]   = act;
        cmd_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid[d] = 1'b0;
        cmd_op[d]    = 2'b11;
    endtask

    task automatic do_write(input int d, input logic [3:0] row, input logic [15:0] data);
        issue(d, 2'b00, row, data, 16'h0);
        @(negedge clk);
        check("write_we_busy", {we_o[d], busy[d], pre_o[d]}, 3'b110);
        if (int'(row) < nrows[d]) mem_m[d][row] = data;
    endtask

    task automatic run_op(input int d, input logic [1:0] op, input logic [3:0] row,
                          input logic [15:0] act, input int hold,
                          output logic [15:0] got_r, output logic [63:0] got_a);
        logic [14:0] seq;
        logic [15:0] exp_r;
        logic [63:0] exp_a;
        int lat;
        issue(d, op, row, 16'h0, act);
        seq = '0;
        lat = 0;
        @(negedge clk);
        while (rsp_valid[d] !== 1'b1 && lat < 20) begin
            seq = {seq[11:0], pre_o[d], eval_o[d], saen_o[d]};
            lat++;
            @(negedge clk);
        end
        got_r = rsp_rdata[d];
        got_a = rsp_adc[d];
        if (lat >= 20) begin
            timeout("rsp_valid");
            return;
        end
        check("latency", lat, 5);
        check("strobe_order", seq, STROBE_SEQ);
        if (op == 2'b10) begin
            exp_r = '0;
            exp_a = mac_model(d, act);
        end else begin
            exp_r = (int'(row) < nrows[d]) ? mem_m[d][row] : 16'h0;
            exp_a = '0;
        end
        check("rsp_rdata", rsp_rdata[d], exp_r);
        check("rsp_adc", rsp_adc[d], exp_a);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid_ready", {rsp_valid[d], cmd_ready[d], busy[d]}, 3'b101);
            check("bp_data", {rsp_rdata[d], rsp_adc[d][47:0]}, {exp_r, exp_a[47:0]});
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        @(negedge clk);
        check("post_handshake", {rsp_valid[d], busy[d], cmd_ready[d]}, 3'b001);
        check("data_held", rsp_rdata[d], exp_r);
    endtask

    task automatic nop_check(input int d);
        issue(d, 2'b11, 4'd0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nop_idle", {cmd_ready[d], busy[d], rsp_valid[d], we_o[d]}, 4'b1000);
        end
    endtask

    initial begin
        logic [15:0] r;
        logic [63:0] a;
        logic [3:0]  rw;
        nrows[0] = 16; nrows[1] = 12;
        shft[0]  = 0;  shft[1]  = 1;
        rst       = 1'b1;
        cmd_valid = '0;
        rsp_ready = '0;
        cmd_op    = {2'b11, 2'b11};
        cmd_row   = '0;
        cmd_wdata = '0;
        cmd_act   = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_ctrl", {rsp_valid[d], pre_o[d], eval_o[d], saen_o[d], we_o[d],
                                 busy[d], cmd_ready[d]}, 7'b0000001);
            check("reset_data", {rsp_rdata[d], rsp_adc[d][47:0]}, 64'h0);
        end
        rst = 1'b0;

        // Write then read on the default build.
        do_write(0, 4'd3, 16'hA5C3);
        run_op(0, 2'b01, 4'd3, 16'h0, 0, r, a);
        check("read_row3", {r, a[47:0]}, {16'hA5C3, 48'h0});

        // Random contents and a mix of reads and MACs.
        for (int i = 0; i < 16; i++) do_write(0, 4'(i), 16'($urandom()));
        for (int i = 0; i < 10; i++) begin
            run_op(0, ($urandom_range(1) != 0) ? 2'b10 : 2'b01, 4'($urandom_range(15)),
                   16'($urandom()), $urandom_range(3), r, a);
        end

        // Saturation.
        for (int i = 0; i < 16; i++) do_write(0, 4'(i), 16'hFFFF);
        run_op(0, 2'b10, 4'd0, 16'hFFFF, 0, r, a);
        check("mac_sat_all", {r, a}, {16'h0, {16{4'hF}}});
        run_op(0, 2'b10, 4'd0, 16'h00FF, 0, r, a);
        check("mac_half", a, {16{4'h8}});

        // Per-column counts.
        for (int i = 0; i < 16; i++) do_write(0, 4'(i), 16'h0000);
        do_write(0, 4'd0, 16'h0001);
        do_write(0, 4'd1, 16'h0003);
        do_write(0, 4'd2, 16'h0007);
        run_op(0, 2'b10, 4'd0, 16'h0007, 0, r, a);
        check("mac_percol", a, 64'h123);

        // Backpressure for ten cycles, then an immediate follow-on command.
        run_op(0, 2'b01, 4'd2, 16'h0, 10, r, a);
        do_write(0, 4'd9, 16'h1234);
        nop_check(0);

        // Reset during evaluate of a read.
        do_write(0, 4'd5, 16'h5A5A);
        issue(0, 2'b01, 4'd5, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        check("eval_before_reset", {pre_o[0], eval_o[0]}, 2'b01);
        #1 rst = 1'b1;
        #1;
        check("reset_midop", {rsp_valid[0], pre_o[0], eval_o[0], saen_o[0], we_o[0], busy[0]},
              6'b000000);
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 2'b01, 4'd5, 16'h0, 0, r, a);
        check("read_after_reset", r, 16'h5A5A);

        // ROWS=12, ADC_SHIFT=1 build.
        for (int i = 0; i < 12; i++) do_write(1, 4'(i), 16'h0000);
        do_write(1, 4'd0, 16'h0001);
        do_write(1, 4'd1, 16'h0003);
        do_write(1, 4'd2, 16'h0007);
        run_op(1, 2'b10, 4'd0, 16'h0007, 0, r, a);
        check("mac_shift1", a, 64'h011);
        nop_check(1);
        do_write(1, 4'd13, 16'hBEEF);
        run_op(1, 2'b01, 4'd13, 16'h0, 0, r, a);
        check("read_oor", {r, a[47:0]}, 64'h0);
        for (int i = 0; i < 12; i++) run_op(1, 2'b01, 4'(i), 16'h0, 0, r, a);
        for (int i = 0; i < 12; i++) do_write(1, 4'(i), 16'($urandom()));
        for (int i = 0; i < 6; i++) begin
            rw = 4'($urandom_range(15));
            run_op(1, ($urandom_range(1) != 0) ? 2'b10 : 2'b01, rw, 16'($urandom()),
                   $urandom_range(2), r, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
